// File: rtl/nf_chk_pkg.sv
// Shared types and constants for the egress port checker.
// FSM states, counter width and port-index width live here.
package nf_chk_pkg;

    localparam int CNT_W      = 32;
    localparam int PORT_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_CMP   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SKIP  = 2'd2
    } chk_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/nf_chk_fifo.sv
// Synchronous first-word-fall-through FIFO holding expected beats.
// Head entry is visible on dout whenever empty is low.
module nf_chk_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         rd_en,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axis_port_tx_checker.sv
// Compares observed egress AXIS beats against a queued expected stream.
// Define NF_CHK_TIMEOUT_EN to build the per-port watchdog.
module axis_port_tx_checker
    import nf_chk_pkg::*;
#(
    parameter int C_NUM_PORTS  = 4,
    parameter int C_DATA_WIDTH = 64,
    parameter int C_EXP_DEPTH  = 512,
    parameter int C_TIMEOUT    = 65535
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_DATA_WIDTH-1:0]           s_exp_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]         s_exp_tkeep,
    input  logic                              s_exp_tlast,
    input  logic                              s_exp_tvalid,
    input  logic [7:0]                        s_exp_tuser,
    output logic                              s_exp_tready,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     mon_tdata,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0]   mon_tkeep,
    input  logic [C_NUM_PORTS-1:0]            mon_tvalid,
    input  logic [C_NUM_PORTS-1:0]            mon_tready,
    input  logic [C_NUM_PORTS-1:0]            mon_tlast,
    input  logic                              clear,
    output logic [C_NUM_PORTS*CNT_W-1:0]      pkt_ok_cnt,
    output logic [C_NUM_PORTS*CNT_W-1:0]      pkt_err_cnt,
    output logic [C_NUM_PORTS-1:0]            err_sticky,
    output logic [C_NUM_PORTS-1:0]            timeout
);

    localparam int KW = C_DATA_WIDTH / 8;
    localparam int FW = C_DATA_WIDTH + KW + 1;

    function automatic logic [PORT_IDX_W-1:0] wrap_idx(
        input logic [2:0] idx
    );
        return PORT_IDX_W'(int'(idx) % C_NUM_PORTS);
    endfunction

    logic                  rdy_en;
    logic                  in_pkt;
    logic [PORT_IDX_W-1:0] cur_port;
    logic [PORT_IDX_W-1:0] sel_port;
    logic [C_NUM_PORTS-1:0] fifo_full;
    logic [7:0]            full8;
    logic                  exp_hs;
    logic [FW-1:0]         exp_din;
    logic                  unused_tuser;

    assign unused_tuser = ^s_exp_tuser[7:3];

    // Destination is taken from tuser only on the first beat of a packet
    assign sel_port = in_pkt ? cur_port : wrap_idx(s_exp_tuser[2:0]);

    always_comb begin
        full8 = '0;
        full8[C_NUM_PORTS-1:0] = fifo_full;
    end

    assign s_exp_tready = rdy_en && !full8[sel_port];
    assign exp_hs       = s_exp_tvalid && s_exp_tready;
    assign exp_din      = {s_exp_tlast, s_exp_tkeep, s_exp_tdata};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rdy_en   <= 1'b0;
            in_pkt   <= 1'b0;
            cur_port <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (exp_hs) begin
                in_pkt   <= !s_exp_tlast;
                cur_port <= sel_port;
            end
        end
    end

    for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_port

        logic                    push;
        logic                    pop;
        logic                    empty;
        logic [FW-1:0]           head;
        logic [C_DATA_WIDTH-1:0] exp_data;
        logic [KW-1:0]           exp_keep;
        logic                    exp_last;
        logic [C_DATA_WIDTH-1:0] obs_data;
        logic [KW-1:0]           obs_keep;
        logic                    obs_last;
        logic                    obs_v;
        logic                    dmatch;
        logic                    match;
        chk_state_e              st;
        chk_state_e              st_nxt;
        logic                    bad;
        logic                    bad_nxt;
        logic                    inc_ok;
        logic                    inc_err;
        logic                    set_stk;
        logic [CNT_W-1:0]        ok_cnt;
        logic [CNT_W-1:0]        err_cnt;
        logic                    stk;

        assign push = exp_hs && (sel_port == PORT_IDX_W'(g));

        nf_chk_fifo #(
            .W     (FW),
            .DEPTH (C_EXP_DEPTH)
        ) u_fifo (
            .clk   (axi_aclk),
            .rst_n (axi_aresetn),
            .wr_en (push),
            .din   (exp_din),
            .rd_en (pop),
            .dout  (head),
            .empty (empty),
            .full  (fifo_full[g])
        );

        assign exp_data = head[C_DATA_WIDTH-1:0];
        assign exp_keep = head[C_DATA_WIDTH +: KW];
        assign exp_last = head[FW-1];

        assign obs_data = mon_tdata[g*C_DATA_WIDTH +: C_DATA_WIDTH];
        assign obs_keep = mon_tkeep[g*KW +: KW];
        assign obs_last = mon_tlast[g];
        assign obs_v    = mon_tvalid[g] && mon_tready[g];

        // Only bytes the expected beat marks valid take part in the compare
        always_comb begin
            dmatch = 1'b1;
            for (int i = 0; i < KW; i++) begin
                if (exp_keep[i] &&
                    obs_data[8*i +: 8] != exp_data[8*i +: 8])
                    dmatch = 1'b0;
            end
        end

        assign match = dmatch && (obs_keep == exp_keep) &&
                       (obs_last == exp_last);

        always_comb begin
            st_nxt  = st;
            bad_nxt = bad;
            inc_ok  = 1'b0;
            inc_err = 1'b0;
            set_stk = 1'b0;
            pop     = 1'b0;
            unique case (st)
                ST_CMP: begin
                    if (obs_v && empty) begin
                        set_stk = 1'b1;
                        inc_err = obs_last;
                        bad_nxt = !obs_last;
                    end else if (obs_v) begin
                        pop = 1'b1;
                        if (obs_last && exp_last) begin
                            inc_ok  = !bad && match;
                            inc_err = bad || !match;
                            bad_nxt = 1'b0;
                        end else if (obs_last) begin
                            inc_err = 1'b1;
                            bad_nxt = 1'b0;
                            st_nxt  = ST_FLUSH;
                        end else if (exp_last) begin
                            inc_err = 1'b1;
                            bad_nxt = 1'b0;
                            st_nxt  = ST_SKIP;
                        end else if (!match) begin
                            bad_nxt = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    pop     = !empty;
                    set_stk = obs_v;
                    if (!empty && exp_last)
                        st_nxt = ST_CMP;
                end
                ST_SKIP: begin
                    if (obs_v && obs_last)
                        st_nxt = ST_CMP;
                end
                default: st_nxt = ST_CMP;
            endcase
        end

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                st  <= ST_CMP;
                bad <= 1'b0;
            end else begin
                st  <= st_nxt;
                bad <= bad_nxt;
            end
        end

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                ok_cnt  <= '0;
                err_cnt <= '0;
                stk     <= 1'b0;
            end else if (clear) begin
                ok_cnt  <= '0;
                err_cnt <= '0;
                stk     <= 1'b0;
            end else begin
                if (inc_ok)
                    ok_cnt <= sat_inc(ok_cnt);
                if (inc_err)
                    err_cnt <= sat_inc(err_cnt);
                if (inc_err || set_stk)
                    stk <= 1'b1;
            end
        end

        assign pkt_ok_cnt[g*CNT_W +: CNT_W]  = ok_cnt;
        assign pkt_err_cnt[g*CNT_W +: CNT_W] = err_cnt;
        assign err_sticky[g]                 = stk;

`ifdef NF_CHK_TIMEOUT_EN
        localparam int TW = $clog2(C_TIMEOUT + 1);

        logic [TW-1:0] wd_cnt;
        logic          wd_flag;
        logic          wd_run;

        assign wd_run = !empty && !obs_v;

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                wd_cnt  <= '0;
                wd_flag <= 1'b0;
            end else begin
                if (obs_v)
                    wd_cnt <= '0;
                else if (wd_run && wd_cnt != TW'(C_TIMEOUT))
                    wd_cnt <= wd_cnt + 1'b1;
                if (clear)
                    wd_flag <= 1'b0;
                else if (wd_run && wd_cnt == TW'(C_TIMEOUT - 1))
                    wd_flag <= 1'b1;
            end
        end

        assign timeout[g] = wd_flag;
`else
        assign timeout[g] = 1'b0;
`endif

    end

endmodule

// File: tb/tb_axis_port_tx_checker.sv
// Scoreboard bench for axis_port_tx_checker.
// Expected packet outcomes are queued as stimulus is driven.
module tb_axis_port_tx_checker;

    localparam int NP  = 4;
    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int DEP = 16;
    localparam int TMO = 100;

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     s_exp_tdata;
    logic [KW-1:0]     s_exp_tkeep;
    logic              s_exp_tlast;
    logic              s_exp_tvalid;
    logic [7:0]        s_exp_tuser;
    logic              s_exp_tready;
    logic [NP*DW-1:0]  mon_tdata;
    logic [NP*KW-1:0]  mon_tkeep;
    logic [NP-1:0]     mon_tvalid;
    logic [NP-1:0]     mon_tready;
    logic [NP-1:0]     mon_tlast;
    logic              clear;
    logic [NP*32-1:0]  pkt_ok_cnt;
    logic [NP*32-1:0]  pkt_err_cnt;
    logic [NP-1:0]     err_sticky;
    logic [NP-1:0]     timeout;

    int checks = 0;
    int errors = 0;

    logic [3:0]  sb_q [$];
    logic [31:0] prev_ok  [NP];
    logic [31:0] prev_err [NP];

    axis_port_tx_checker #(
        .C_NUM_PORTS  (NP),
        .C_DATA_WIDTH (DW),
        .C_EXP_DEPTH  (DEP),
        .C_TIMEOUT    (TMO)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .s_exp_tdata  (s_exp_tdata),
        .s_exp_tkeep  (s_exp_tkeep),
        .s_exp_tlast  (s_exp_tlast),
        .s_exp_tvalid (s_exp_tvalid),
        .s_exp_tuser  (s_exp_tuser),
        .s_exp_tready (s_exp_tready),
        .mon_tdata    (mon_tdata),
        .mon_tkeep    (mon_tkeep),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tlast    (mon_tlast),
        .clear        (clear),
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_err_cnt  (pkt_err_cnt),
        .err_sticky   (err_sticky),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bd(input int seed, input int i);
        return {32'(seed), 32'(i)} ^ 64'hA5C3_5A3C_0F1E_F0E1;
    endfunction

    // Counter increments are the DUT output events matched to the queue
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            logic [31:0] ok_v;
            logic [31:0] er_v;
            ok_v = pkt_ok_cnt[p*32 +: 32];
            er_v = pkt_err_cnt[p*32 +: 32];
            if (rst_n && ok_v > prev_ok[p]) begin
                if (sb_q.size() == 0)
                    chk("sb_unexp_ok", 64'(p), 64'hFF);
                else
                    chk("sb_evt", 64'({3'(p), 1'b1}),
                        64'(sb_q.pop_front()));
            end
            if (rst_n && er_v > prev_err[p]) begin
                if (sb_q.size() == 0)
                    chk("sb_unexp_err", 64'(p), 64'hFF);
                else
                    chk("sb_evt", 64'({3'(p), 1'b0}),
                        64'(sb_q.pop_front()));
            end
            prev_ok[p]  = ok_v;
            prev_err[p] = er_v;
        end
    end

    task automatic exp_drive(input int dst, input logic [63:0] d,
                             input logic [7:0] k, input logic l);
        s_exp_tvalid = 1'b1;
        s_exp_tdata  = d;
        s_exp_tkeep  = k;
        s_exp_tlast  = l;
        s_exp_tuser  = 8'(dst);
    endtask

    task automatic exp_beat(input int dst, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
        int n;
        n = 0;
        exp_drive(dst, d, k, l);
        forever begin
            #1;
            if (s_exp_tready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("exp_ready_tmo", 64'(n), 0);
                break;
            end
        end
    endtask

    task automatic exp_pkt(input int dst, input int seed, input int n,
                           input logic [7:0] lk);
        for (int i = 0; i < n; i++)
            exp_beat(dst, bd(seed, i), (i == n-1) ? lk : 8'hFF,
                     i == n-1);
        s_exp_tvalid = 1'b0;
    endtask

    task automatic obs_beat(input int p, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
        mon_tdata[p*DW +: DW] = d;
        mon_tkeep[p*KW +: KW] = k;
        mon_tlast[p]  = l;
        mon_tvalid[p] = 1'b1;
        mon_tready[p] = 1'b1;
        @(negedge clk);
        mon_tvalid[p] = 1'b0;
        mon_tready[p] = 1'b0;
    endtask

    task automatic obs_pkt(input int p, input int seed, input int n,
                           input logic [7:0] lk, input int fb,
                           input int fbyte);
        for (int i = 0; i < n; i++) begin
            logic [63:0] d;
            d = bd(seed, i);
            if (i == fb)
                d[8*fbyte +: 8] = d[8*fbyte +: 8] ^ 8'h5A;
            obs_beat(p, d, (i == n-1) ? lk : 8'hFF, i == n-1);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        chk(tag, 64'(sb_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 exp 0");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            prev_ok[p]  = '0;
            prev_err[p] = '0;
        end
        rst_n        = 1'b0;
        clear        = 1'b0;
        s_exp_tvalid = 1'b0;
        s_exp_tdata  = '0;
        s_exp_tkeep  = '0;
        s_exp_tlast  = 1'b0;
        s_exp_tuser  = '0;
        mon_tdata    = '0;
        mon_tkeep    = '0;
        mon_tvalid   = '0;
        mon_tready   = '0;
        mon_tlast    = '0;

        repeat (3) @(negedge clk);
        chk("rst_ok", 64'(|pkt_ok_cnt), 0);
        chk("rst_err", 64'(|pkt_err_cnt), 0);
        chk("rst_stk", 64'(err_sticky), 0);
        chk("rst_tmo", 64'(timeout), 0);
        chk("rst_rdy", 64'(s_exp_tready), 0);
        rst_n = 1'b1;
        #1 chk("rdy_pre", 64'(s_exp_tready), 0);
        @(negedge clk);
        chk("rdy_post", 64'(s_exp_tready), 1);

        // three identical 64-byte packets to port 2
        for (int k = 0; k < 3; k++) begin
            exp_pkt(2, 16'h200, 8, 8'hFF);
            sb_q.push_back({3'd2, 1'b1});
            obs_pkt(2, 16'h200, 8, 8'hFF, -1, 0);
        end
        drain("sb_drain_a");
        chk("ok2_x3", 64'(pkt_ok_cnt[2*32 +: 32]), 3);
        chk("err_none", 64'(|pkt_err_cnt), 0);
        chk("stk_none", 64'(err_sticky), 0);

        // byte mismatch, then the same byte masked by tkeep
        exp_pkt(1, 16'h310, 8, 8'hFF);
        sb_q.push_back({3'd1, 1'b0});
        obs_pkt(1, 16'h310, 8, 8'hFF, 3, 5);
        exp_pkt(1, 16'h320, 4, 8'h1F);
        sb_q.push_back({3'd1, 1'b1});
        obs_pkt(1, 16'h320, 4, 8'h1F, 3, 5);
        drain("sb_drain_b");
        chk("err1_byte", 64'(pkt_err_cnt[1*32 +: 32]), 1);
        chk("ok1_masked", 64'(pkt_ok_cnt[1*32 +: 32]), 1);
        chk("stk1", 64'(err_sticky), 64'b0010);
        do_clear();
        chk("clr_ok", 64'(|pkt_ok_cnt), 0);
        chk("clr_err", 64'(|pkt_err_cnt), 0);
        chk("clr_stk", 64'(err_sticky), 0);

        // short observed packet (flush) and long observed packet (skip)
        exp_pkt(3, 16'h400, 8, 8'hFF);
        sb_q.push_back({3'd3, 1'b0});
        obs_pkt(3, 16'h400, 6, 8'hFF, -1, 0);
        repeat (4) @(negedge clk);
        exp_pkt(3, 16'h410, 3, 8'hFF);
        sb_q.push_back({3'd3, 1'b1});
        obs_pkt(3, 16'h410, 3, 8'hFF, -1, 0);
        exp_pkt(3, 16'h420, 4, 8'hFF);
        sb_q.push_back({3'd3, 1'b0});
        obs_pkt(3, 16'h420, 6, 8'hFF, -1, 0);
        exp_pkt(3, 16'h430, 2, 8'hFF);
        sb_q.push_back({3'd3, 1'b1});
        obs_pkt(3, 16'h430, 2, 8'hFF, -1, 0);
        // observed packet with nothing queued; tuser 4 wraps to port 0
        sb_q.push_back({3'd0, 1'b0});
        obs_pkt(0, 16'h500, 3, 8'hFF, -1, 0);
        drain("sb_drain_c");
        chk("err3", 64'(pkt_err_cnt[3*32 +: 32]), 2);
        chk("ok3", 64'(pkt_ok_cnt[3*32 +: 32]), 2);
        chk("err0_empty", 64'(pkt_err_cnt[0*32 +: 32]), 1);
        chk("stk_30", 64'(err_sticky), 64'b1001);
        exp_pkt(4, 16'h510, 2, 8'hFF);
        sb_q.push_back({3'd0, 1'b1});
        obs_pkt(0, 16'h510, 2, 8'hFF, -1, 0);
        drain("sb_drain_d");
        chk("ok0_wrap", 64'(pkt_ok_cnt[0*32 +: 32]), 1);
        do_clear();

        // fill port 0, then drain it while port 1 traffic follows
        for (int i = 0; i < DEP; i++)
            exp_beat(0, bd(16'h600, i), 8'hFF, 1'b0);
        exp_drive(0, bd(16'h600, DEP), 8'hFF, 1'b0);
        #1 chk("full_bp", 64'(s_exp_tready), 0);
        @(negedge clk);
        #1 chk("full_hold", 64'(s_exp_tready), 0);
        sb_q.push_back({3'd0, 1'b1});
        fork
            begin
                for (int i = DEP; i < 20; i++)
                    exp_beat(0, bd(16'h600, i), 8'hFF, i == 19);
                exp_pkt(1, 16'h610, 4, 8'hFF);
            end
            obs_pkt(0, 16'h600, 20, 8'hFF, -1, 0);
        join
        sb_q.push_back({3'd1, 1'b1});
        obs_pkt(1, 16'h610, 4, 8'hFF, -1, 0);
        drain("sb_drain_e");
        chk("ok0_full", 64'(pkt_ok_cnt[0*32 +: 32]), 1);
        chk("ok1_after", 64'(pkt_ok_cnt[1*32 +: 32]), 1);
        chk("err_full", 64'(|pkt_err_cnt), 0);

        // watchdog on a queued packet that is never observed
        exp_pkt(1, 16'h700, 4, 8'hFF);
        repeat (90) @(negedge clk);
        chk("tmo_early", 64'(timeout), 0);
        repeat (12) @(negedge clk);
`ifdef NF_CHK_TIMEOUT_EN
        chk("tmo_set", 64'(timeout), 64'b0010);
`else
        chk("tmo_off", 64'(timeout), 0);
`endif
        do_clear();
        chk("tmo_clr", 64'(timeout), 0);
        sb_q.push_back({3'd1, 1'b1});
        obs_pkt(1, 16'h700, 4, 8'hFF, -1, 0);
        drain("sb_drain_f");
        chk("ok1_tmo", 64'(pkt_ok_cnt[1*32 +: 32]), 1);

        // reset with packets half-way on both streams
        exp_beat(2, bd(16'h800, 0), 8'hFF, 1'b0);
        exp_beat(2, bd(16'h800, 1), 8'hFF, 1'b0);
        s_exp_tvalid = 1'b0;
        obs_beat(2, bd(16'h800, 0), 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ok", 64'(|pkt_ok_cnt), 0);
        chk("mid_rst_err", 64'(|pkt_err_cnt), 0);
        chk("mid_rst_stk", 64'(err_sticky), 0);
        chk("mid_rst_rdy", 64'(s_exp_tready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_pkt(2, 16'h900, 4, 8'hFF);
        sb_q.push_back({3'd2, 1'b1});
        obs_pkt(2, 16'h900, 4, 8'hFF, -1, 0);
        drain("sb_drain_g");
        chk("ok2_fresh", 64'(pkt_ok_cnt[2*32 +: 32]), 1);
        chk("err_fresh", 64'(|pkt_err_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_port_tx_checker.md
AXIS_PORT_TX_CHECKER -- requirements
Module: axis_port_tx_checker

Interface
REQ-001 SHALL have parameter C_NUM_PORTS, default 4: number of monitored egress ports (1..8).
REQ-002 SHALL have parameter C_DATA_WIDTH, default 64: tdata width in bits, a multiple of 8.
REQ-003 SHALL have parameter C_EXP_DEPTH, default 512: per-port expected-beat FIFO depth, a power of 2.
REQ-004 SHALL have parameter C_TIMEOUT, default 65535: watchdog limit in cycles.
REQ-005 SHALL have port axi_aclk, input, 1: the single clock; all logic is on rising edge.
REQ-006 SHALL have port axi_aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have s_exp_tdata/tkeep/tlast/tvalid, inputs, C_DATA_WIDTH/C_DATA_WIDTH/8/1/1: expected-packet stream.
REQ-008 SHALL have s_exp_tuser, input, 8: bits [2:0] carry the destination port index of the packet.
REQ-009 SHALL have s_exp_tready, output, 1: expected-stream backpressure.
REQ-010 SHALL have mon_tdata/tkeep, inputs, C_NUM_PORTS x (C_DATA_WIDTH, C_DATA_WIDTH/8), flattened with port 0 in the LSBs: passively observed egress data.
REQ-011 SHALL have mon_tvalid/tready/tlast, inputs, C_NUM_PORTS each: observed handshake; the checker never drives tready.
REQ-012 SHALL have clear, input, 1: synchronous clear of counters and flags.
REQ-013 SHALL have pkt_ok_cnt and pkt_err_cnt, outputs, C_NUM_PORTS x 32: per-port packet counters.
REQ-014 SHALL have err_sticky, output, C_NUM_PORTS: per-port error flag.
REQ-015 SHALL have timeout, output, C_NUM_PORTS: per-port watchdog flag.

Function
REQ-016 SHALL latch the destination index on the first beat of each expected packet, with an index >= C_NUM_PORTS wrapped modulo C_NUM_PORTS, and route all beats through tlast to that port's FIFO.
REQ-017 SHALL hold s_exp_tready low while the target FIFO is full; no beat is lost or duplicated.
REQ-018 SHALL treat an observed beat as mon_tvalid&mon_tready; each observed beat pops exactly one expected beat in state CMP.
REQ-019 SHALL define a beat match as: tkeep equal, tdata equal on bytes with tkeep=1 only, and tlast equal.
REQ-020 SHALL run a per-port FSM with states CMP, FLUSH and SKIP; reset state is CMP.
REQ-021 SHALL, in CMP, on an observed tlast where the expected beat is also last, increment ok if all beats matched, else increment err; then remain in CMP.
REQ-022 SHALL, in CMP, on an observed tlast where the expected beat is not last, increment err and go to FLUSH.
REQ-023 SHALL, in FLUSH, pop one expected beat per cycle until expected tlast is popped, then return to CMP; observed beats arriving in FLUSH are dropped and set err_sticky.
REQ-024 SHALL, in CMP, on an expected tlast popped against a non-last observed beat, increment err and go to SKIP.
REQ-025 SHALL, in SKIP, drop observed beats through observed tlast, then return to CMP.
REQ-026 SHALL, on an observed beat with the FIFO empty in CMP, drop the beat, set err_sticky, and count one err packet at its tlast.
REQ-027 SHALL update counters one cycle after the deciding beat, and set err_sticky in the same cycle as any err increment.
REQ-028 SHALL saturate counters at 0xFFFFFFFF.
REQ-029 SHALL give clear priority over a simultaneous increment; clear leaves FSM and FIFO contents unchanged.

Reset
REQ-030 SHALL, on axi_aresetn low, immediately set counters, err_sticky and timeout to 0, s_exp_tready to 0, FIFOs to empty and FSMs to CMP.
REQ-031 SHALL discard a partial packet in flight at reset; after release, the next observed beat is treated as a packet start.
REQ-032 SHALL drive s_exp_tready high one cycle after reset release if the FIFOs are not full.

Configuration
REQ-033 SHALL, with NF_CHK_TIMEOUT_EN defined, keep a per-port cycle counter that runs while the FIFO is non-empty and no observed beat occurs, resets on any observed beat, and sets sticky timeout at C_TIMEOUT; clear resets the flag.
REQ-034 SHALL, without NF_CHK_TIMEOUT_EN, tie timeout to 0 and synthesize no watchdog logic.

Structure
REQ-035 SHALL take the FSM state enum, counter width (32) and port-index width constant from shared package nf_chk_pkg.
REQ-036 SHALL use one sub-module nf_chk_fifo (synchronous FWFT FIFO, width C_DATA_WIDTH+C_DATA_WIDTH/8+1), instantiated once per port.

Verification
REQ-037 SHALL verify: 3 identical 64B packets to port 2 -> pkt_ok_cnt[2]=3, all err=0.
REQ-038 SHALL verify: byte 5 differs with tkeep=0xFF -> err_cnt=1, err_sticky=1; same byte differs with tkeep=0x1F on last beat -> ok_cnt=1.
REQ-039 SHALL verify: expected 8 beats, observed 6 then a good packet -> err=1 via FLUSH, ok=1.
REQ-040 SHALL verify: a full FIFO on port 0 -> s_exp_tready low while port 1 traffic is unaffected once the port 0 packet ends.
REQ-041 SHALL verify: with NF_CHK_TIMEOUT_EN and C_TIMEOUT=100, a queued packet with no observed beats -> timeout[k]=1 at cycle 100, and 0 after clear.
REQ-042 SHALL verify: reset mid-packet -> all outputs 0, then a fresh packet -> ok_cnt=1.
